vlg_cnt_seq_ctrl: RTL and testbench

Sequencing controller for a pair of free-running-style 4-bit counters.
- A start pulse runs counter 1 through 0..TC1, then counter 2 through 0..TC2, and repeats this pair for a programmed number of rounds.
- It ends with a one-cycle done pulse.
- It sits between a host/test-sequencer (start, pause, config) and the counter datapath it owns.
- It replaces ungated always-counting with controlled enable and clear.

---
 rtl/vlg_cnt_seq_defs.sv | 15 +
 rtl/vlg_cnt_unit.sv | 25 ++
 rtl/vlg_cnt_seq_ctrl.sv | 110 +++++++++++
 tb/tb_vlg_cnt_seq_ctrl.sv | 167 ++++++++++++++++
 4 files changed

// File: rtl/vlg_cnt_seq_defs.sv
// Shared definitions for the counter sequencing controller.
// Holds the FSM state encoding and the default counter and round widths.
package vlg_cnt_seq_defs;

    localparam int CNT_W_DEF = 4;
    localparam int RND_W_DEF = 4;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_RUN1 = 2'd1,
        ST_RUN2 = 2'd2,
        ST_DONE = 2'd3
    } state_t;

endpackage

// File: rtl/vlg_cnt_unit.sv
// Phase counter: counts 0..tc when enabled, then returns to 0 by compare, not by wrap.
// A clear has priority over the enable.
module vlg_cnt_unit #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         clr,
    input  logic         en,
    input  logic [W-1:0] tc,
    output logic [W-1:0] cnt,
    output logic         at_tc
);

    assign at_tc = (cnt == tc);

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= at_tc ? '0 : cnt + W'(1);
        end
    end

endmodule

// File: rtl/vlg_cnt_seq_ctrl.sv
// Sequencing controller: runs counter 1 then counter 2 for a latched number of rounds,
// then emits a one-cycle done pulse. Pause freezes all run state.
module vlg_cnt_seq_ctrl
    import vlg_cnt_seq_defs::*;
#(
    parameter int CNT_W = CNT_W_DEF,
    parameter int RND_W = RND_W_DEF
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_start,
    input  logic             i_pause,
    input  logic [CNT_W-1:0] i_tc1,
    input  logic [CNT_W-1:0] i_tc2,
    input  logic [RND_W-1:0] i_rounds,
    output logic [CNT_W-1:0] o_cnt1,
    output logic [CNT_W-1:0] o_cnt2,
    output logic [RND_W-1:0] o_round,
    output logic             o_busy,
    output logic             o_done
);

    state_t state, next_state;

    logic [CNT_W-1:0] tc1_q, tc2_q;
    logic [RND_W-1:0] rounds_q, round_q;
    logic             start_ok, en1, en2, at_tc1, at_tc2, last_round;

    assign start_ok   = (state == ST_IDLE) && i_start;
    assign en1        = (state == ST_RUN1) && !i_pause;
    assign en2        = (state == ST_RUN2) && !i_pause;
    assign last_round = (round_q == rounds_q - RND_W'(1));

    vlg_cnt_unit #(.W(CNT_W)) u_cnt1 (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (start_ok),
        .en    (en1),
        .tc    (tc1_q),
        .cnt   (o_cnt1),
        .at_tc (at_tc1)
    );

    vlg_cnt_unit #(.W(CNT_W)) u_cnt2 (
        .clk   (i_clk),
        .rst   (i_rst),
        .clr   (start_ok),
        .en    (en2),
        .tc    (tc2_q),
        .cnt   (o_cnt2),
        .at_tc (at_tc2)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= ST_IDLE;
        end else begin
            state <= next_state;
        end
    end

    always_comb begin
        next_state = state;
        case (state)
            ST_IDLE: begin
                if (i_start) begin
                    next_state = (i_rounds == '0) ? ST_DONE : ST_RUN1;
                end
            end
            ST_RUN1: begin
                if (en1 && at_tc1) begin
                    next_state = ST_RUN2;
                end
            end
            ST_RUN2: begin
                if (en2 && at_tc2) begin
                    next_state = last_round ? ST_DONE : ST_RUN1;
                end
            end
            ST_DONE: next_state = ST_IDLE;
            default: next_state = ST_IDLE;
        endcase
    end

    // Config is captured only on an accepted start, so changes while busy are ignored.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            tc1_q    <= '0;
            tc2_q    <= '0;
            rounds_q <= '0;
        end else if (start_ok) begin
            tc1_q    <= i_tc1;
            tc2_q    <= i_tc2;
            rounds_q <= i_rounds;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst || start_ok) begin
            round_q <= '0;
        end else if (en2 && at_tc2) begin
            round_q <= last_round ? '0 : round_q + RND_W'(1);
        end
    end

    assign o_round = round_q;
    assign o_busy  = (state == ST_RUN1) || (state == ST_RUN2);
    assign o_done  = (state == ST_DONE);

endmodule

// File: tb/tb_vlg_cnt_seq_ctrl.sv
// Self-checking bench: each run's expected output trace is built as a queue from the
// sequencing rules, then replayed cycle by cycle with pause, noise and reset injection.
module tb_vlg_cnt_seq_ctrl;

    typedef struct packed {
        logic [3:0] c1;
        logic [3:0] c2;
        logic [3:0] rnd;
        logic       busy;
        logic       done;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_start = 1'b0;
    logic       i_pause = 1'b0;
    logic [3:0] i_tc1 = '0;
    logic [3:0] i_tc2 = '0;
    logic [3:0] i_rounds = '0;
    logic [3:0] o_cnt1, o_cnt2, o_round;
    logic       o_busy, o_done;

    int n_checks = 0;
    int n_fail   = 0;

    vlg_cnt_seq_ctrl dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_start  (i_start),
        .i_pause  (i_pause),
        .i_tc1    (i_tc1),
        .i_tc2    (i_tc2),
        .i_rounds (i_rounds),
        .o_cnt1   (o_cnt1),
        .o_cnt2   (o_cnt2),
        .o_round  (o_round),
        .o_busy   (o_busy),
        .o_done   (o_done)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string tag, input int obs, input int expv);
        n_checks++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic check_entry(input string tag, input exp_t e);
        check({tag, ".cnt1"},  int'(o_cnt1),  int'(e.c1));
        check({tag, ".cnt2"},  int'(o_cnt2),  int'(e.c2));
        check({tag, ".round"}, int'(o_round), int'(e.rnd));
        check({tag, ".busy"},  int'(o_busy),  int'(e.busy));
        check({tag, ".done"},  int'(o_done),  int'(e.done));
    endtask

    task automatic tick();
        @(posedge i_clk);
        #1;
    endtask

    // mode: 0 no pause, 1 random pause, 2 three-cycle pause at trace index 2 plus idle/done pauses
    task automatic run_seq(input string tag, input int tc1, input int tc2, input int rounds,
                           input int mode, input bit noise, input int abort_idx);
        exp_t q[$];
        exp_t idle_e;
        int   idx, cyc, paused, pause_left;
        bit   p, used, reached;
        idle_e = '0;
        for (int r = 0; r < rounds; r++) begin
            for (int c = 0; c <= tc1; c++) q.push_back('{4'(c), 4'd0, 4'(r), 1'b1, 1'b0});
            for (int c = 0; c <= tc2; c++) q.push_back('{4'd0, 4'(c), 4'(r), 1'b1, 1'b0});
        end
        q.push_back('{4'd0, 4'd0, 4'd0, 1'b0, 1'b1});

        i_tc1    = 4'(tc1);
        i_tc2    = 4'(tc2);
        i_rounds = 4'(rounds);
        i_start  = 1'b1;
        i_pause  = (mode == 2);
        tick();
        i_start = 1'b0;
        i_pause = 1'b0;
        idx = 0; cyc = 1; paused = 0; pause_left = 0; used = 0; reached = 0;

        for (int guard = 0; guard < 2000; guard++) begin
            check_entry(tag, q[idx]);
            if (q[idx].done) begin
                check({tag, ".done_cycle"}, cyc, q.size() + paused);
                reached = 1;
                break;
            end
            if (idx == abort_idx) begin
                i_rst = 1'b1;
                tick();
                i_rst = 1'b0;
                check_entry({tag, ".abort"}, idle_e);
                tick();
                check_entry({tag, ".abort_idle"}, idle_e);
                return;
            end
            if (mode == 2 && idx == 2 && !used) begin
                pause_left = 3;
                used = 1;
            end
            if (mode == 1) p = ($urandom_range(3) == 0);
            else if (pause_left > 0) begin
                p = 1;
                pause_left--;
            end else p = 0;
            i_pause = p;
            if (noise) begin
                i_start  = 1'($urandom);
                i_tc1    = 4'($urandom);
                i_tc2    = 4'($urandom);
                i_rounds = 4'($urandom);
            end
            tick();
            cyc++;
            if (p) paused++;
            else idx++;
        end
        if (!reached) check({tag, ".timeout"}, 0, 1);

        // Start and pause during DONE must neither extend it nor restart the sequence.
        i_start = noise ? 1'b1 : 1'b0;
        i_pause = (mode != 0);
        tick();
        i_start = 1'b0;
        i_pause = 1'b0;
        check_entry({tag, ".idle"}, idle_e);
        tick();
        check_entry({tag, ".idle2"}, idle_e);
    endtask

    initial begin
        exp_t idle_e;
        idle_e = '0;
        i_tc1 = 4'd9; i_tc2 = 4'd9; i_rounds = 4'd9; i_start = 1'b1;
        tick();
        tick();
        check_entry("reset", idle_e);
        i_rst   = 1'b0;
        i_start = 1'b0;
        tick();
        check_entry("post_reset", idle_e);

        run_seq("nominal", 3, 2, 2, 0, 0, -1);
        run_seq("zero_rounds", 5, 5, 0, 0, 0, -1);
        run_seq("pause", 3, 2, 2, 2, 0, -1);
        run_seq("abort", 3, 2, 2, 0, 0, 12);
        run_seq("after_abort", 3, 2, 2, 0, 0, -1);
        run_seq("noise", 3, 2, 2, 0, 1, -1);
        run_seq("extreme_max", 15, 15, 15, 0, 0, -1);
        run_seq("extreme_min", 0, 0, 1, 0, 0, -1);
        for (int k = 0; k < 8; k++) begin
            run_seq("random", int'($urandom_range(6)), int'($urandom_range(6)),
                    int'($urandom_range(4)), 1, 1'(k & 1), -1);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
